// File: rtl/mux_slave_2to1.sv
// Two-master to one-slave request mux with grant-steered response routing.
// Define MUX_SLAVE_OUT_REG_EN to register the slave-side request and the grant (1-cycle latency).
module mux_slave_2to1 (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  grant,
  input  logic        req_in_first,
  input  logic        req_in_second,
  input  logic [31:0] addr_in_first,
  input  logic [31:0] addr_in_second,
  input  logic [31:0] wdata_in_first,
  input  logic [31:0] wdata_in_second,
  input  logic        cmd_in_first,
  input  logic        cmd_in_second,
  output logic        ack_in_first,
  output logic        ack_in_second,
  output logic [31:0] rdata_in_first,
  output logic [31:0] rdata_in_second,
  output logic        req_out,
  output logic [31:0] addr_out,
  output logic        cmd_out,
  output logic [31:0] wdata_out,
  input  logic        ack_out,
  input  logic [31:0] rdata_out
);

  logic        req_mux;
  logic [31:0] addr_mux;
  logic        cmd_mux;
  logic [31:0] wdata_mux;
  logic [1:0]  resp_sel;

  // Grant is not guaranteed one-hot: 00 and 11 both park the slave side idle.
  always_comb begin
    req_mux   = 1'b0;
    addr_mux  = 32'h0;
    cmd_mux   = 1'b0;
    wdata_mux = 32'h0;
    case (grant)
      2'b01: begin
        req_mux   = req_in_first;
        addr_mux  = addr_in_first;
        cmd_mux   = cmd_in_first;
        wdata_mux = wdata_in_first;
      end
      2'b10: begin
        req_mux   = req_in_second;
        addr_mux  = addr_in_second;
        cmd_mux   = cmd_in_second;
        wdata_mux = wdata_in_second;
      end
      default: ;
    endcase
  end

`ifdef MUX_SLAVE_OUT_REG_EN
  logic        req_q;
  logic [31:0] addr_q;
  logic        cmd_q;
  logic [31:0] wdata_q;
  logic [1:0]  grant_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      req_q   <= 1'b0;
      addr_q  <= 32'h0;
      cmd_q   <= 1'b0;
      wdata_q <= 32'h0;
      grant_q <= 2'b00;
    end else begin
      req_q   <= req_mux;
      addr_q  <= addr_mux;
      cmd_q   <= cmd_mux;
      wdata_q <= wdata_mux;
      grant_q <= grant;
    end
  end

  assign req_out   = req_q;
  assign addr_out  = addr_q;
  assign cmd_out   = cmd_q;
  assign wdata_out = wdata_q;
  // Responses follow the owner of the request currently presented to the slave.
  assign resp_sel  = grant_q;
`else
  logic unused_clk;
  assign unused_clk = clk;

  assign req_out   = rst ? 1'b0  : req_mux;
  assign addr_out  = rst ? 32'h0 : addr_mux;
  assign cmd_out   = rst ? 1'b0  : cmd_mux;
  assign wdata_out = rst ? 32'h0 : wdata_mux;
  assign resp_sel  = rst ? 2'b00 : grant;
`endif

  always_comb begin
    ack_in_first    = 1'b0;
    ack_in_second   = 1'b0;
    rdata_in_first  = 32'h0;
    rdata_in_second = 32'h0;
    case (resp_sel)
      2'b01: begin
        ack_in_first   = ack_out;
        rdata_in_first = rdata_out;
      end
      2'b10: begin
        ack_in_second   = ack_out;
        rdata_in_second = rdata_out;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mux_slave_2to1.sv
// Directed self-checking bench for mux_slave_2to1; checks are sampled 1 ns after the rising edge,
// which is valid for both the combinational and the registered build.
module tb_mux_slave_2to1;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  grant;
  logic        req_in_first, req_in_second;
  logic [31:0] addr_in_first, addr_in_second;
  logic [31:0] wdata_in_first, wdata_in_second;
  logic        cmd_in_first, cmd_in_second;
  logic        ack_in_first, ack_in_second;
  logic [31:0] rdata_in_first, rdata_in_second;
  logic        req_out;
  logic [31:0] addr_out;
  logic        cmd_out;
  logic [31:0] wdata_out;
  logic        ack_out;
  logic [31:0] rdata_out;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  mux_slave_2to1 dut (
    .clk             (clk),
    .rst             (rst),
    .grant           (grant),
    .req_in_first    (req_in_first),
    .req_in_second   (req_in_second),
    .addr_in_first   (addr_in_first),
    .addr_in_second  (addr_in_second),
    .wdata_in_first  (wdata_in_first),
    .wdata_in_second (wdata_in_second),
    .cmd_in_first    (cmd_in_first),
    .cmd_in_second   (cmd_in_second),
    .ack_in_first    (ack_in_first),
    .ack_in_second   (ack_in_second),
    .rdata_in_first  (rdata_in_first),
    .rdata_in_second (rdata_in_second),
    .req_out         (req_out),
    .addr_out        (addr_out),
    .cmd_out         (cmd_out),
    .wdata_out       (wdata_out),
    .ack_out         (ack_out),
    .rdata_out       (rdata_out)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_acks(input string tag, input logic af, input logic [31:0] rf,
                            input logic as_, input logic [31:0] rs);
    check_val({tag, "_ack1"}, {31'h0, ack_in_first}, {31'h0, af});
    check_val({tag, "_rd1"}, rdata_in_first, rf);
    check_val({tag, "_ack2"}, {31'h0, ack_in_second}, {31'h0, as_});
    check_val({tag, "_rd2"}, rdata_in_second, rs);
  endtask

  initial begin
    rst = 1'b1;
    grant = 2'b01;
    req_in_first = 1'b1;
    req_in_second = 1'b1;
    addr_in_first = 32'hCCCCCCCC;
    wdata_in_first = 32'hAAAAAAAA;
    cmd_in_first = 1'b0;
    addr_in_second = 32'h33333333;
    wdata_in_second = 32'h55555555;
    cmd_in_second = 1'b1;
    ack_out = 1'b1;
    rdata_out = 32'h75757575;

    // Reset with an active request and a live slave response
    step();
    step();
    check_val("rst_req", {31'h0, req_out}, 32'h0);
    check_val("rst_addr", addr_out, 32'h0);
    check_val("rst_wdata", wdata_out, 32'h0);
    check_acks("rst", 1'b0, 32'h0, 1'b0, 32'h0);

    // First master owns the slave
    rst = 1'b0;
    step();
    check_val("g01_req", {31'h0, req_out}, 32'h1);
    check_val("g01_addr", addr_out, 32'hCCCCCCCC);
    check_val("g01_wdata", wdata_out, 32'hAAAAAAAA);
    check_val("g01_cmd", {31'h0, cmd_out}, 32'h0);
    check_acks("g01", 1'b1, 32'h75757575, 1'b0, 32'h0);

    // Second master owns the slave
    grant = 2'b10;
`ifdef MUX_SLAVE_OUT_REG_EN
    #1;
    check_val("lat_addr", addr_out, 32'hCCCCCCCC);
    check_val("lat_ack1", {31'h0, ack_in_first}, 32'h1);
`else
    #1;
    check_val("same_cyc_addr", addr_out, 32'h33333333);
    check_val("same_cyc_ack2", {31'h0, ack_in_second}, 32'h1);
`endif
    step();
    check_val("g10_req", {31'h0, req_out}, 32'h1);
    check_val("g10_addr", addr_out, 32'h33333333);
    check_val("g10_wdata", wdata_out, 32'h55555555);
    check_val("g10_cmd", {31'h0, cmd_out}, 32'h1);
    check_acks("g10", 1'b0, 32'h0, 1'b1, 32'h75757575);

    // Toggle back to the first master
    grant = 2'b01;
    step();
    check_val("g01b_cmd", {31'h0, cmd_out}, 32'h0);
    check_acks("g01b", 1'b1, 32'h75757575, 1'b0, 32'h0);

    // Non-granted request ignored: first idle while second requests
    req_in_first = 1'b0;
    step();
    check_val("ign_req", {31'h0, req_out}, 32'h0);
    req_in_first = 1'b1;

    // No-owner grant codes
    grant = 2'b00;
    step();
    check_val("g00_req", {31'h0, req_out}, 32'h0);
    check_val("g00_addr", addr_out, 32'h0);
    check_val("g00_wdata", wdata_out, 32'h0);
    check_acks("g00", 1'b0, 32'h0, 1'b0, 32'h0);

    grant = 2'b11;
    step();
    check_val("g11_req", {31'h0, req_out}, 32'h0);
    check_val("g11_addr", addr_out, 32'h0);
    check_val("g11_cmd", {31'h0, cmd_out}, 32'h0);
    check_acks("g11", 1'b0, 32'h0, 1'b0, 32'h0);

    // Reset mid-transaction, then release
    grant = 2'b01;
    step();
    check_val("pre_rst_req", {31'h0, req_out}, 32'h1);
    rst = 1'b1;
    step();
    check_val("mid_rst_req", {31'h0, req_out}, 32'h0);
    check_val("mid_rst_addr", addr_out, 32'h0);
    check_acks("mid_rst", 1'b0, 32'h0, 1'b0, 32'h0);
    rst = 1'b0;
    step();
    check_val("post_rst_req", {31'h0, req_out}, 32'h1);
    check_val("post_rst_addr", addr_out, 32'hCCCCCCCC);
    check_acks("post_rst", 1'b1, 32'h75757575, 1'b0, 32'h0);

    // Response data routed verbatim with ack low
    ack_out = 1'b0;
    rdata_out = 32'h12345678;
    step();
    check_acks("noack", 1'b0, 32'h12345678, 1'b0, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
